// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell codes, board type, writer FSM states,
// direction decode and the start position.
package othello_pkg;

   localparam logic [1:0] BLACK = 2'd0;
   localparam logic [1:0] WHITE = 2'd1;
   localparam logic [1:0] EMPTY = 2'd2;

   typedef logic [1:0] cell_t;
   typedef cell_t board_t [0:7][0:7];

   typedef enum logic [2:0] {
      IDLE,
      PLACE,
      SCAN,
      FLIP,
      DONE
   } state_t;

   typedef struct packed {
      logic signed [3:0] dr;
      logic signed [3:0] dc;
   } dir_t;

   function automatic dir_t dir_of(input logic [2:0] d);
      dir_t v;
      unique case (d)
         3'd0:    v = '{dr: -4'sd1, dc: -4'sd1};
         3'd1:    v = '{dr: -4'sd1, dc:  4'sd0};
         3'd2:    v = '{dr: -4'sd1, dc:  4'sd1};
         3'd3:    v = '{dr:  4'sd0, dc: -4'sd1};
         3'd4:    v = '{dr:  4'sd0, dc:  4'sd1};
         3'd5:    v = '{dr:  4'sd1, dc: -4'sd1};
         3'd6:    v = '{dr:  4'sd1, dc:  4'sd0};
         default: v = '{dr:  4'sd1, dc:  4'sd1};
      endcase
      return v;
   endfunction

   function automatic board_t start_board();
      board_t b;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            b[r][c] = EMPTY;
         end
      end
      b[3][3] = WHITE;
      b[4][4] = WHITE;
      b[3][4] = BLACK;
      b[4][3] = BLACK;
      return b;
   endfunction

endpackage

// File: rtl/othello_board_writer_if.sv
// Move-request / board-status bundle of the board writer.
// master drives the move request, slave (the writer) returns board and status.
interface othello_board_writer_if;
   import othello_pkg::*;

   logic            i_init;
   logic            i_start;
   logic [2:0]      i_step_row;
   logic [2:0]      i_step_col;
   logic            i_color;
   logic [7:0][4:0] i_flip_num;
   board_t          o_board;
   logic            o_busy;
   logic            o_done;
   logic            o_illegal;
   logic [5:0]      o_total;

   modport master (
      output i_init, i_start, i_step_row, i_step_col, i_color, i_flip_num,
      input  o_board, o_busy, o_done, o_illegal, o_total
   );

   modport slave (
      input  i_init, i_start, i_step_row, i_step_col, i_color, i_flip_num,
      output o_board, o_busy, o_done, o_illegal, o_total
   );

endinterface

// File: rtl/othello_board_writer.sv
// Owns the 8x8 board; places a stone then flips one cell per cycle per direction.
// Ports: i_clk, i_rst_n (async low), bus (slave: move request in, board/status out).
module othello_board_writer
   import othello_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   othello_board_writer_if.slave  bus
);

   state_t            state_q, state_d;
   board_t            board_q, board_d;
   logic [2:0]        row_q, row_d;
   logic [2:0]        col_q, col_d;
   logic [2:0]        d_q, d_d;
   logic              color_q, color_d;
   logic [7:0][4:0]   cnt_q, cnt_d;
   logic signed [3:0] cur_r_q, cur_r_d;
   logic signed [3:0] cur_c_q, cur_c_d;
   logic [4:0]        remain_q, remain_d;
   logic [5:0]        total_q, total_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              illegal_q, illegal_d;

   logic [7:0]        cnt_sum;
   dir_t              dv;
   logic              on_board;
   logic              dir_end;

   always_comb begin
      state_d   = state_q;
      board_d   = board_q;
      row_d     = row_q;
      col_d     = col_q;
      d_d       = d_q;
      color_d   = color_q;
      cnt_d     = cnt_q;
      cur_r_d   = cur_r_q;
      cur_c_d   = cur_c_q;
      remain_d  = remain_q;
      total_d   = total_q;
      illegal_d = 1'b0;
      dir_end   = 1'b0;
      dv        = dir_of(d_q);
      // -1 and 8 both read as negative in 4-bit signed
      on_board  = !cur_r_q[3] && !cur_c_q[3];
      cnt_sum   = '0;
      for (int i = 0; i < 8; i++) begin
         cnt_sum = cnt_sum + 8'(bus.i_flip_num[i]);
      end

      unique case (state_q)
         IDLE: begin
            if (bus.i_init) begin
               board_d = start_board();
            end else if (bus.i_start) begin
               row_d   = bus.i_step_row;
               col_d   = bus.i_step_col;
               color_d = bus.i_color;
               cnt_d   = bus.i_flip_num;
               total_d = '0;
               // codes 2 and 3 are empty: bit 1 set
               if (!board_q[bus.i_step_row][bus.i_step_col][1]
                   || cnt_sum == 8'd0) begin
                  state_d   = DONE;
                  illegal_d = 1'b1;
               end else begin
                  state_d = PLACE;
               end
            end
         end
         PLACE: begin
            board_d[row_q][col_q] = {1'b0, color_q};
            d_d     = '0;
            state_d = SCAN;
         end
         SCAN: begin
            if (cnt_q[d_q] != 5'd0) begin
               cur_r_d  = $signed({1'b0, row_q}) + dv.dr;
               cur_c_d  = $signed({1'b0, col_q}) + dv.dc;
               remain_d = cnt_q[d_q];
               state_d  = FLIP;
            end else begin
               dir_end = 1'b1;
            end
         end
         FLIP: begin
            if (on_board) begin
               board_d[cur_r_q[2:0]][cur_c_q[2:0]] = {1'b0, color_q};
               total_d  = total_q + 6'd1;
               remain_d = remain_q - 5'd1;
               cur_r_d  = cur_r_q + dv.dr;
               cur_c_d  = cur_c_q + dv.dc;
               dir_end  = (remain_q == 5'd1);
            end else begin
               dir_end = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (dir_end) begin
         if (d_q == 3'd7) begin
            state_d = DONE;
         end else begin
            d_d     = d_q + 3'd1;
            state_d = SCAN;
         end
      end

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         board_q   <= start_board();
         row_q     <= '0;
         col_q     <= '0;
         d_q       <= '0;
         color_q   <= 1'b0;
         cnt_q     <= '0;
         cur_r_q   <= '0;
         cur_c_q   <= '0;
         remain_q  <= '0;
         total_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         board_q   <= board_d;
         row_q     <= row_d;
         col_q     <= col_d;
         d_q       <= d_d;
         color_q   <= color_d;
         cnt_q     <= cnt_d;
         cur_r_q   <= cur_r_d;
         cur_c_q   <= cur_c_d;
         remain_q  <= remain_d;
         total_q   <= total_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.o_board   = board_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_done    = done_q;
   assign bus.o_illegal = illegal_q;
   assign bus.o_total   = total_q;

endmodule

// File: tb/tb_othello_board_writer.sv
// Self-checking bench for othello_board_writer: hand vectors, corner
// sequences and random moves against a geometric reference board.
module tb_othello_board_writer;
   import othello_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   othello_board_writer_if bus();

   othello_board_writer dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int tests = 0;
   int fails = 0;
   int mb[8][8];
   int cv[8];
   int DR[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
   int DC[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

   typedef struct {
      int r, c, col;
      int da, na, db, nb;
      int tot, ill, lat;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_board(input string nm);
      int bad = 0;
      int br = 0, bc = 0, ba = 0, be = 0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (int'(bus.o_board[r][c]) != mb[r][c]) begin
               if (bad == 0) begin
                  br = r; bc = c;
                  ba = int'(bus.o_board[r][c]);
                  be = mb[r][c];
               end
               bad++;
            end
         end
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL %s.board: %0d cells differ, first (%0d,%0d) got %0d expected %0d",
                  nm, bad, br, bc, ba, be);
      end
   endtask

   function automatic void model_start();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            mb[r][c] = 2;
      mb[3][3] = 1; mb[4][4] = 1;
      mb[3][4] = 0; mb[4][3] = 0;
   endfunction

   // Latency is edges after the start edge until o_done is seen high.
   function automatic void model_move(input int r, input int c, input int col,
                                      input int cnt[8],
                                      output int tot, output int ill, output int lat);
      int sum = 0;
      for (int d = 0; d < 8; d++) sum += cnt[d];
      tot = 0;
      if (mb[r][c] < 2 || sum == 0) begin
         ill = 1;
         lat = 0;
         return;
      end
      ill = 0;
      mb[r][c] = col;
      lat = 9;
      for (int d = 0; d < 8; d++) begin
         for (int k = 1; k <= cnt[d]; k++) begin
            int rr = r + k * DR[d];
            int cc = c + k * DC[d];
            lat++;
            if (rr < 0 || rr > 7 || cc < 0 || cc > 7) break;
            mb[rr][cc] = col;
            tot++;
         end
      end
   endfunction

   function automatic void mkc(input int da, input int na, input int db, input int nb);
      for (int d = 0; d < 8; d++) cv[d] = 0;
      cv[da] += na;
      cv[db] += nb;
   endfunction

   task automatic do_init();
      @(negedge clk);
      bus.i_init = 1'b1;
      @(posedge clk);
      #1;
      bus.i_init = 1'b0;
      model_start();
   endtask

   task automatic drive_start(input int r, input int c, input int col, input int cnt[8]);
      @(negedge clk);
      bus.i_step_row = 3'(r);
      bus.i_step_col = 3'(c);
      bus.i_color    = 1'(col);
      for (int d = 0; d < 8; d++) bus.i_flip_num[d] = 5'(cnt[d]);
      bus.i_start = 1'b1;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
   endtask

   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      while (!bus.o_done && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!bus.o_done) lat = -1;
   endtask

   task automatic check_move(input string nm, input int r, input int c,
                             input int col, input int cnt[8],
                             output int at, output int ai, output int al);
      int et, ei, el;
      model_move(r, c, col, cnt, et, ei, el);
      drive_start(r, c, col, cnt);
      wait_done(0, al);
      at = int'(bus.o_total);
      ai = int'(bus.o_illegal);
      chk({nm, ".total"}, at, et);
      chk({nm, ".illegal"}, ai, ei);
      chk({nm, ".latency"}, al, el);
      @(posedge clk);
      #1;
      chk({nm, ".busy_after"}, int'(bus.o_busy), 0);
      chk_board(nm);
   endtask

   initial begin
      int at, ai, al, et, ei, el, lat;
      int rr, cc, col;
      int cnt[8];

      bus.i_init = 1'b0;
      bus.i_start = 1'b0;
      bus.i_step_row = '0;
      bus.i_step_col = '0;
      bus.i_color = 1'b0;
      bus.i_flip_num = '0;

      tbl[0] = '{2, 3, 0, 6, 1, 0, 0, 1, 0, 10};
      tbl[1] = '{3, 3, 0, 6, 1, 0, 0, 0, 1, 0};
      tbl[2] = '{2, 2, 1, 0, 0, 0, 0, 0, 1, 0};
      tbl[3] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 10};
      tbl[4] = '{7, 7, 1, 7, 2, 0, 0, 0, 0, 10};
      tbl[5] = '{0, 7, 1, 2, 5, 5, 3, 3, 0, 13};
      tbl[6] = '{5, 5, 0, 4, 5, 0, 0, 2, 0, 12};
      tbl[7] = '{4, 4, 0, 0, 1, 0, 0, 0, 1, 0};
      tbl[8] = '{2, 4, 1, 6, 2, 3, 7, 6, 0, 16};

      model_start();
      #12;
      chk("rst.busy", int'(bus.o_busy), 0);
      chk("rst.done", int'(bus.o_done), 0);
      chk("rst.illegal", int'(bus.o_illegal), 0);
      chk("rst.total", int'(bus.o_total), 0);
      chk_board("rst");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         do_init();
         mkc(tbl[i].da, tbl[i].na, tbl[i].db, tbl[i].nb);
         check_move(nm, tbl[i].r, tbl[i].c, tbl[i].col, cv, at, ai, al);
         chk({nm, ".hand_total"}, at, tbl[i].tot);
         chk({nm, ".hand_illegal"}, ai, tbl[i].ill);
         chk({nm, ".hand_latency"}, al, tbl[i].lat);
      end

      // black diagonal (1,1)..(6,6), white (7,7), then white sweeps from (0,0)
      do_init();
      mkc(0, 5, 0, 0);
      check_move("diag_build_a", 6, 6, 0, cv, at, ai, al);
      mkc(7, 1, 0, 0);
      check_move("diag_build_b", 7, 7, 1, cv, at, ai, al);
      mkc(7, 7, 0, 0);
      check_move("diag", 0, 0, 1, cv, at, ai, al);
      chk("diag.hand_total", at, 7);
      chk("diag.hand_latency", al, 16);
      chk("diag.cell77", int'(bus.o_board[7][7]), 1);
      chk("diag.cell44", int'(bus.o_board[4][4]), 1);

      // i_start / i_init while busy are ignored
      do_init();
      mkc(6, 1, 0, 0);
      model_move(2, 3, 0, cv, et, ei, el);
      drive_start(2, 3, 0, cv);
      chk("busy.high", int'(bus.o_busy), 1);
      lat = 0;
      repeat (3) begin
         @(negedge clk);
         bus.i_start = 1'b1;
         bus.i_init = 1'b1;
         bus.i_step_row = 3'd5;
         bus.i_step_col = 3'd5;
         bus.i_color = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
      bus.i_start = 1'b0;
      bus.i_init = 1'b0;
      wait_done(lat, al);
      chk("busy.latency", al, el);
      chk("busy.total", int'(bus.o_total), et);
      chk("busy.illegal", int'(bus.o_illegal), ei);
      @(posedge clk);
      #1;
      chk_board("busy");

      // reset in the middle of the diagonal sweep
      do_init();
      mkc(0, 5, 0, 0);
      check_move("rstmid_a", 6, 6, 0, cv, at, ai, al);
      mkc(7, 1, 0, 0);
      check_move("rstmid_b", 7, 7, 1, cv, at, ai, al);
      mkc(7, 7, 0, 0);
      drive_start(0, 0, 1, cv);
      repeat (12) @(posedge clk);
      #1;
      chk("rstmid.busy_before", int'(bus.o_busy), 1);
      rst_n = 1'b0;
      #2;
      model_start();
      chk("rstmid.busy", int'(bus.o_busy), 0);
      chk("rstmid.done", int'(bus.o_done), 0);
      chk("rstmid.total", int'(bus.o_total), 0);
      chk_board("rstmid");
      @(negedge clk);
      rst_n = 1'b1;

      // random moves on a running board
      for (int i = 0; i < 40; i++) begin
         if (i % 10 == 0) do_init();
         rr = int'($urandom_range(0, 7));
         cc = int'($urandom_range(0, 7));
         col = int'($urandom_range(0, 1));
         for (int d = 0; d < 8; d++)
            cnt[d] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
         check_move($sformatf("rnd%0d", i), rr, cc, col, cnt, at, ai, al);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/othello_board_writer.md
# othello_board_writer

Applies a validated Othello move to the game board: owns the 8x8 board register, places the mover's stone and flips the enemy stones indicated by eight per-direction flip counts, one stone per cycle. It sits downstream of the eight per-direction flip calculators. Those calculators read the board and produce counts; this block consumes the counts and writes the board. Its o_board output feeds both the calculators and the display logic.

## Interface
- No parameters.
- i_clk  in  1  clock; rising-edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_init  in  1  in IDLE: load the start position in one cycle.
- i_start  in  1  in IDLE: begin applying a move.
- i_step_row  in  3  row of the placed stone, 0..7.
- i_step_col  in  3  column of the placed stone, 0..7.
- i_color  in  1  mover's colour: 0 black, 1 white.
- i_flip_num  in  8x5  unsigned flip count per direction index 0..7.
- o_board  out  8x8x2  current board; cell codes 0 black, 1 white, 2 empty, 3 treated as empty.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse at end of a move.
- o_illegal  out  1  valid only with o_done; high if the move was rejected.
- o_total  out  6  stones actually flipped by the last move; held until next i_start.

## Operation
- Direction index to (drow, dcol): 0 (-1,-1), 1 (-1,0), 2 (-1,+1), 3 (0,-1), 4 (0,+1), 5 (+1,-1), 6 (+1,0), 7 (+1,+1).
- States: IDLE, PLACE, SCAN, FLIP, DONE.
- **IDLE**
  - i_init: board loads the start position; stay in IDLE.
  - i_start (i_init low): latch step, colour and all eight counts; clear o_total.
  - Then go to DONE with illegal flag set if either:
    - the target cell is not empty (code 0 or 1), or
    - the sum of the eight counts is 0.
  - Otherwise go to PLACE.
  - i_init and i_start together: i_init wins and the move is dropped.
- **PLACE**: write colour to the target cell; d=0; go to SCAN.
- **SCAN** at direction d:
  - Count > 0: set cursor = step + dir(d) and remain = count; go to FLIP.
  - Count = 0: if d = 7 go to DONE, else increment d and stay in SCAN.
- **FLIP**
  - Cursor inside 0..7 on both axes: write colour at the cursor, increment o_total, decrement remain, step the cursor by dir(d).
  - Cursor off-board: no write; end this direction immediately.
  - Direction ends when remain reaches 0 or the cursor goes off-board. Then: if d = 7 go to DONE, else increment d and return to SCAN.
- **DONE**: o_done = 1; o_illegal reflects the flag; go to IDLE.
- Cursor is signed 4-bit per axis, so the off-board test covers -1 and 8.
- The counts are not re-validated against cell contents; flipped cells are overwritten unconditionally.
- Only one cell is written per cycle.
- i_start and i_init are ignored while o_busy is high.

## Timing
- Reset (asynchronous):
  - state IDLE; board = start position;
  - o_busy 0, o_done 0, o_illegal 0, o_total 0.
- Start position: [3][3]=1, [4][4]=1, [3][4]=0, [4][3]=0, all other cells 2.
- Reset mid-move abandons the move. The board reverts to the start position with no partial state retained.
- Legal move, i_start sampled at edge E0, T = o_total:
  - PLACE after E0; SCAN cycles for d=0..7; T FLIP cycles.
  - o_done is high in the cycle after edge E(9+T).
  - Board writes become visible on o_board at the edge following the writing state's cycle.
- Illegal move: o_done is high in the cycle after E0; the board is unchanged.
- o_busy rises in the cycle after E0 and falls in the cycle after DONE. A new i_start is accepted the cycle o_busy is low.
- o_total width: maximum 8x7 = 56 fits in 6 bits. The running sum is saturation-free.

## Structure
- Shared package othello_pkg holds:
  - cell constants BLACK=0, WHITE=1, EMPTY=2;
  - the board typedef (logic [1:0] [0:7][0:7]);
  - the state enum;
  - a function mapping direction index to signed (drow, dcol).
- The flip calculators use the same package constants.
- No sub-module: a single FSM plus the board register. The start-position constant lives in the package.

## Test plan
- Reset, then sample o_board: only the four centre cells are set as specified; o_busy 0, o_total 0.
- From the start position, black (0) at (2,3), counts d6=1, others 0:
  - (2,3) and (3,3) become 0;
  - o_total=1;
  - o_done 10 edges after start;
  - o_illegal 0.
- Target (3,3), which is occupied → o_done on the next cycle, o_illegal 1, board unchanged.
- All counts 0 on an empty target → o_illegal 1, board unchanged.
- White at (0,0) with d7=7 on a board whose diagonal (1,1)..(6,6) is black and (7,7) is white:
  - diagonal cells 1..6 become 1, and (7,7) is also written 1 because it is in bounds and counts are not re-validated;
  - o_total=7;
  - latency 16.
- Counts pointing off-board (stone at (0,0), d0=3) → no writes in that direction, o_total excludes them. Also check:
  - i_start while busy is ignored;
  - asserting i_rst_n low mid-FLIP restores the start position.
